// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3
// access encodings, error codes and the request legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_MISAL   = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Illegal funct3 is reported ahead of misalignment.
    function automatic logic [1:0] check_req(input logic       is_store,
                                             input logic [2:0] f3,
                                             input logic [1:0] addr_lo);
        logic legal;
        case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !is_store;
            default:          legal = 1'b0;
        endcase
        if (!legal)
            return ERR_ILLEGAL;
        if (f3[1:0] == 2'b01 && addr_lo[0])
            return ERR_MISAL;
        if (f3[1:0] == 2'b10 && addr_lo != 2'b00)
            return ERR_MISAL;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and replicated write data for
// stores, and lane extraction with sign/zero extension for loads.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_value
);

    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        sel_byte   = rd_byte[addr_lo];
        sel_half   = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        mem_be     = 4'b0000;
        mem_wdata  = 32'd0;
        load_value = 32'd0;
        case (funct3)
            F3_B: begin
                mem_be     = 4'b0001 << addr_lo;
                mem_wdata  = {4{store_data[7:0]}};
                load_value = {{24{sel_byte[7]}}, sel_byte};
            end
            F3_BU: begin
                mem_be     = 4'b0001 << addr_lo;
                load_value = {24'd0, sel_byte};
            end
            F3_H: begin
                mem_be     = 4'b0011 << addr_lo;
                mem_wdata  = {2{store_data[15:0]}};
                load_value = {{16{sel_half[15]}}, sel_half};
            end
            F3_HU: begin
                mem_be     = 4'b0011 << addr_lo;
                load_value = {16'd0, sel_half};
            end
            F3_W: begin
                mem_be     = 4'b1111;
                mem_wdata  = store_data;
                load_value = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: accepts one access at a time from execute, runs a single
// request/ready bus cycle with timeout, and reports done/err with load data.
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic             store_q;
    logic             busy_reg, done_reg, mem_req_reg, mem_we_reg;
    logic [1:0]       err_reg;
    logic [31:0]      load_data_reg, mem_addr_reg, mem_wdata_reg;
    logic [3:0]       mem_be_reg;

    logic [2:0]  align_f3;
    logic [1:0]  align_addr;
    logic [3:0]  align_be;
    logic [31:0] align_wdata, align_load;
    logic [1:0]  req_err;

    // In IDLE the aligner sees the incoming request so bus fields can be
    // registered at acceptance; afterwards it works from the captured copy.
    assign align_f3   = (state_reg == IDLE) ? funct3 : funct3_q;
    assign align_addr = (state_reg == IDLE) ? addr[1:0] : addr_lo_q;
    assign req_err    = check_req(req_store, funct3, addr[1:0]);

    lsu_lane_align u_align (
        .funct3     (align_f3),
        .addr_lo    (align_addr),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .mem_be     (align_be),
        .mem_wdata  (align_wdata),
        .load_value (align_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            funct3_q      <= '0;
            addr_lo_q     <= '0;
            store_q       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= ERR_NONE;
            load_data_reg <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= '0;
            mem_wdata_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= funct3;
                        addr_lo_q <= addr[1:0];
                        store_q   <= req_store;
                        busy_reg  <= 1'b1;
                        if (req_err != ERR_NONE) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            err_reg   <= req_err;
                        end else begin
                            state_reg     <= BUS;
                            cnt_reg       <= '0;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= req_store;
                            mem_addr_reg  <= {addr[31:2], 2'b00};
                            mem_be_reg    <= align_be;
                            mem_wdata_reg <= req_store ? align_wdata : 32'd0;
                        end
                    end
                end
                BUS: begin
                    // Ready in the expiry cycle still counts as success.
                    if (mem_ready || cnt_reg == CNT_LAST) begin
                        state_reg     <= DONE;
                        done_reg      <= 1'b1;
                        err_reg       <= mem_ready ? ERR_NONE : ERR_TIMEOUT;
                        mem_req_reg   <= 1'b0;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= '0;
                        mem_be_reg    <= '0;
                        mem_wdata_reg <= '0;
                        if (mem_ready && !store_q)
                            load_data_reg <= align_load;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    err_reg   <= ERR_NONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign load_data = load_data_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed vector table, randomized accesses
// against a byte-level reference model, and a mid-access reset sequence.
module tb_lsu_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, done, mem_req, mem_we, mem_ready;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  err;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_load = 32'd0;

    // Observations of the most recent transaction.
    int          o_reqs, o_busy, o_done_at;
    bit          o_stable, o_bus_idle, o_after_idle;
    logic [1:0]  o_err;
    logic [31:0] o_load, o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we;

    lsu_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_store(req_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .load_data(load_data), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [1:0] m_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!ok) return 2'b10;
        if ((int'(a[1:0]) % size_of(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int v;
        v = ((1 << size_of(f3)) - 1) << int'(a[1:0]);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        sz = size_of(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(a[1:0]));
        case (size_of(f3))
            1: v = f3[2] ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            2: v = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: ;
        endcase
        return v;
    endfunction

    // ---------------- driver / monitor ----------------
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int ready_at, input logic [31:0] rdata);
        req_valid = 1'b1; req_store = st; funct3 = f3; addr = a; store_data = d;
        @(posedge clk); #1;
        req_valid = 1'b0; req_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; store_data = $urandom;
        o_reqs = 0; o_busy = 0; o_done_at = 0; o_stable = 1; o_bus_idle = 0;
        o_err = 2'bxx; o_load = 'x; o_be = '0; o_we = 1'b0; o_addr = '0; o_wdata = '0;
        for (int n = 1; n <= 12 && o_done_at == 0; n++) begin
            if (busy) o_busy++;
            if (mem_req) begin
                o_reqs++;
                if (o_reqs == 1) begin
                    o_be = mem_be; o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
                end else if (mem_be !== o_be || mem_we !== o_we ||
                             mem_addr !== o_addr || mem_wdata !== o_wdata) begin
                    o_stable = 0;
                end
                if (o_reqs == ready_at) begin
                    mem_ready = 1'b1; mem_rdata = rdata;
                end else begin
                    mem_ready = 1'b0; mem_rdata = $urandom;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            end
            if (done) begin
                o_done_at  = n;
                o_err      = err;
                o_load     = load_data;
                o_bus_idle = (mem_we == 1'b0 && mem_be == 4'd0 &&
                              mem_addr == 32'd0 && mem_wdata == 32'd0);
            end
            @(posedge clk); #1;
        end
        o_after_idle = (busy == 1'b0 && done == 1'b0 && mem_req == 1'b0);
    endtask

    task automatic verify(input string tag, input bit st, input logic [31:0] a, input int ready_at,
                          input logic [1:0] e_err, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic [31:0] e_load);
        int e_reqs;
        e_reqs = (e_err == 2'b00) ? ready_at : (e_err == 2'b11) ? TO : 0;
        $display("txn %s st=%0d addr=%h ready_at=%0d err=%0d load=%h reqs=%0d done_at=%0d",
                 tag, st, a, ready_at, o_err, o_load, o_reqs, o_done_at);
        check({tag, ".err"}, 32'(o_err), 32'(e_err));
        check({tag, ".done_at"}, 32'(o_done_at), 32'(e_reqs + 1));
        check({tag, ".req_cycles"}, 32'(o_reqs), 32'(e_reqs));
        check({tag, ".busy_cycles"}, 32'(o_busy), 32'(e_reqs + 1));
        check({tag, ".load_data"}, o_load, e_load);
        check({tag, ".bus_idle_at_done"}, 32'(o_bus_idle), 32'd1);
        check({tag, ".idle_after"}, 32'(o_after_idle), 32'd1);
        if (e_reqs > 0) begin
            check({tag, ".be"}, 32'(o_be), 32'(e_be));
            check({tag, ".we"}, 32'(o_we), 32'(st));
            check({tag, ".mem_addr"}, o_addr, {a[31:2], 2'b00});
            check({tag, ".stable"}, 32'(o_stable), 32'd1);
            if (st) check({tag, ".wdata"}, o_wdata, e_wdata);
        end
    endtask

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        int          ready_at;
        logic [31:0] rdata;
        logic [1:0]  e_err;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'h0,        2'b00, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1, 3'b000, 32'h103, 32'h000000A5, 1, 32'h0,        2'b00, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{0, 3'b000, 32'h103, 32'h0,        1, 32'h80000000, 2'b00, 4'b1000, 32'h0, 32'hFFFFFF80};
        vecs[3]  = '{0, 3'b100, 32'h103, 32'h0,        1, 32'h80000000, 2'b00, 4'b1000, 32'h0, 32'h00000080};
        vecs[4]  = '{0, 3'b001, 32'h202, 32'h0,        2, 32'h9ABC1234, 2'b00, 4'b1100, 32'h0, 32'hFFFF9ABC};
        vecs[5]  = '{0, 3'b101, 32'h202, 32'h0,        1, 32'h9ABC1234, 2'b00, 4'b1100, 32'h0, 32'h00009ABC};
        vecs[6]  = '{0, 3'b010, 32'h101, 32'h0,        1, 32'h11111111, 2'b01, 4'b0000, 32'h0, 32'h00009ABC};
        vecs[7]  = '{0, 3'b011, 32'h101, 32'h0,        1, 32'h11111111, 2'b10, 4'b0000, 32'h0, 32'h00009ABC};
        vecs[8]  = '{1, 3'b010, 32'h104, 32'h01234567, 0, 32'h0,        2'b11, 4'b1111, 32'h01234567, 32'h00009ABC};
        vecs[9]  = '{0, 3'b010, 32'h204, 32'h0,        4, 32'h12345678, 2'b00, 4'b1111, 32'h0, 32'h12345678};
        vecs[10] = '{1, 3'b100, 32'h200, 32'h0,        1, 32'h0,        2'b10, 4'b0000, 32'h0, 32'h12345678};
        vecs[11] = '{1, 3'b001, 32'h102, 32'h0000BEEF, 3, 32'h0,        2'b00, 4'b1100, 32'hBEEFBEEF, 32'h12345678};
        vecs[12] = '{0, 3'b010, 32'h208, 32'h0,        5, 32'hCAFEF00D, 2'b11, 4'b1111, 32'h0, 32'h12345678};

        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; funct3 = '0; addr = '0;
        store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.mem_req", 32'(mem_req), 32'd0);
        check("reset.load_data", load_data, 32'd0);
        check("reset.err", 32'(err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].d, vecs[i].ready_at, vecs[i].rdata);
            verify($sformatf("vec%0d", i), vecs[i].st, vecs[i].a, vecs[i].ready_at,
                   vecs[i].e_err, vecs[i].e_be, vecs[i].e_wdata, vecs[i].e_load);
            model_load = vecs[i].e_load;
        end

        for (int i = 0; i < 150; i++) begin
            bit          st;
            logic [2:0]  f3;
            logic [31:0] a, d, rd;
            int          ra;
            logic [1:0]  e;
            st = 1'($urandom);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (st ? 3'($urandom_range(0, 2))
                 : 3'(($urandom_range(0, 1) << 2) | $urandom_range(0, 1 + ($urandom_range(0, 1) == 0 ? 0 : 1))));
            a  = $urandom; d = $urandom; rd = $urandom;
            ra = $urandom_range(0, TO + 1);
            e  = m_err(st, f3, a);
            if (e == 2'b00 && (ra < 1 || ra > TO)) e = 2'b11;
            if (e == 2'b00 && !st) model_load = m_load(f3, a, rd);
            run_txn(st, f3, a, d, ra, rd);
            verify($sformatf("rnd%0d", i), st, a, ra, e, m_be(f3, a), m_wdata(f3, d), model_load);
        end

        // Reset in the second BUS cycle of a load that would otherwise time out.
        req_valid = 1'b1; req_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstmid.in_bus", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rstmid.mem_req", 32'(mem_req), 32'd0);
        check("rstmid.busy", 32'(busy), 32'd0);
        check("rstmid.done", 32'(done), 32'd0);
        check("rstmid.load_data", load_data, 32'd0);
        #2 rst = 1'b0;
        model_load = 32'd0;
        run_txn(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, 1, 32'h0);
        verify("post_rst_sw", 1'b1, 32'h10, 1, 2'b00, 4'b1111, 32'hA1B2C3D4, 32'h0);

        mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("stray_ready%0d.busy", i), 32'(busy), 32'd0);
            check($sformatf("stray_ready%0d.done", i), 32'(done), 32'd0);
            check($sformatf("stray_ready%0d.load", i), load_data, 32'd0);
        end
        run_txn(1'b0, 3'b001, 32'h42, 32'h0, 2, 32'h7FFF0000);
        verify("post_rst_lh", 1'b0, 32'h42, 2, 2'b00, 4'b1100, 32'h0, 32'h00007FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
